// File: rtl/j1b_pkg.sv
// j1b_pkg: shared definitions for the J1B Forth core.
// Instruction class codes (bits [14:13] when bit 15 is clear), the ALU
// T' operation codes and the bit positions of the ALU instruction fields.
package j1b_pkg;

    localparam logic [1:0] CLS_JMP  = 2'b00;
    localparam logic [1:0] CLS_ZBR  = 2'b01;
    localparam logic [1:0] CLS_CALL = 2'b10;
    localparam logic [1:0] CLS_ALU  = 2'b11;

    typedef enum logic [3:0] {
        OP_T, OP_S, OP_ADD, OP_AND, OP_OR, OP_XOR, OP_INV, OP_EQ,
        OP_SLT, OP_SHR, OP_DEC, OP_R, OP_LD, OP_SHL, OP_DEPTH, OP_ULT
    } alu_op_e;

    localparam int B_LIT  = 15;  // literal marker
    localparam int B_RPC  = 12;  // R -> PC
    localparam int B_TS   = 7;   // T -> S
    localparam int B_TR   = 6;   // T -> R
    localparam int B_ST   = 5;   // store S to [T]
    localparam int B_RETI = 4;   // re-enable interrupts

endpackage

// File: rtl/j1b_stack.sv
// j1b_stack: LIFO with asynchronously read RAM and a wrapping pointer.
// Ports:
//   clk, rst_n   clock, async active-low reset (pointer and fault only)
//   commit       apply delta / write this cycle
//   delta        signed 2-bit pointer change (-2..+1)
//   we, wd       write wd at the post-update pointer
//   top          mem[ptr] (current top of stack)
//   ptr          current pointer
//   fault        sticky: set when the net move leaves 0..2**PW-1
module j1b_stack #(
    parameter int DW = 16,
    parameter int PW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit,
    input  logic signed [1:0] delta,
    input  logic              we,
    input  logic [DW-1:0]     wd,
    output logic [DW-1:0]     top,
    output logic [PW-1:0]     ptr,
    output logic              fault
);
    logic [DW-1:0] mem [0:(2**PW)-1];
    logic [PW+1:0] sum;
    logic [PW-1:0] ptr_n;
    logic          oob;

    // Two guard bits: bit PW+1 flags a move below 0, bit PW a move past the top.
    assign sum   = {2'b00, ptr} + {{PW{delta[1]}}, delta};
    assign ptr_n = sum[PW-1:0];
    assign oob   = sum[PW+1] | sum[PW];
    assign top   = mem[ptr];

    always_ff @(posedge clk) begin
        if (commit && we)
            mem[ptr_n] <= wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            fault <= 1'b0;
        end else if (commit) begin
            ptr   <= ptr_n;
            fault <= fault | oob;
        end
    end
endmodule

// File: rtl/j1b_core.sv
// j1b_core: J1-compatible 16-bit-instruction Forth CPU with a parametrised
// data width, two j1b_stack instances and lock-step Wishbone buses sharing
// one strobe/acknowledge. State commits only on shr_stb_o & shr_ack_i.
// Optional feature macro: J1B_IRQ_EN (level interrupt input irq_i, ie flag).
// Ports:
//   sys_clk_i, sys_res_ni    clock, async active-low reset
//   ins_adr_o/ins_dat_i      instruction address (=PC) / instruction word
//   ins_cyc_o                instruction cycle, high whenever running
//   dat_adr_o/dat_dat_o/dat_dat_i/dat_we_o/dat_cyc_o  data bus (addr=T[DW-1:1], wdata=S)
//   shr_stb_o, shr_ack_i     shared strobe / acknowledge
//   irq_i                    interrupt request (J1B_IRQ_EN only)
//   fault_o                  sticky {rs_fault, ds_fault}
module j1b_core
    import j1b_pkg::*;
#(
    parameter int          DW        = 16,
    parameter int          AW        = 13,
    parameter int          DSP_W     = 5,
    parameter int          RSP_W     = 5,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned IRQ_VEC   = 1
) (
    input  logic          sys_clk_i,
    input  logic          sys_res_ni,
    output logic [AW-1:0] ins_adr_o,
    input  logic [15:0]   ins_dat_i,
    output logic          ins_cyc_o,
    output logic [DW-2:0] dat_adr_o,
    output logic [DW-1:0] dat_dat_o,
    input  logic [DW-1:0] dat_dat_i,
    output logic          dat_we_o,
    output logic          dat_cyc_o,
    output logic          shr_stb_o,
    input  logic          shr_ack_i,
`ifdef J1B_IRQ_EN
    input  logic          irq_i,
`endif
    output logic [1:0]    fault_o
);
    localparam int SHW = $clog2(DW);
    localparam int HW  = DW / 2;

    logic [AW-1:0]    pc, pc_n, pc_inc, tgt;
    logic [DW-1:0]    t, t_n, s, r, alu, rs_wd;
    logic [DSP_W-1:0] dsp;
    logic [RSP_W-1:0] rsp;
    logic signed [1:0] ds_d, rs_d;
    logic             ds_we, rs_we, ds_fault, rs_fault;
    logic             run, commit, is_alu, irq_take;
    alu_op_e          op;

    assign op     = alu_op_e'(ins_dat_i[11:8]);
    assign is_alu = !ins_dat_i[B_LIT] && (ins_dat_i[14:13] == CLS_ALU);
    assign pc_inc = pc + AW'(1);
    assign tgt    = AW'(ins_dat_i[12:0]);

`ifdef J1B_IRQ_EN
    logic ie;
    assign irq_take = irq_i & ie;
`else
    logic unused_reti;
    assign unused_reti = ins_dat_i[B_RETI];
    assign irq_take    = 1'b0;
`endif

    // Bus side: an interrupt entry discards the fetched word, so it must not
    // start a data cycle either.
    assign ins_cyc_o = run;
    assign dat_cyc_o = run & is_alu & ((op == OP_LD) | ins_dat_i[B_ST]) & ~irq_take;
    assign dat_we_o  = dat_cyc_o & ins_dat_i[B_ST];
    assign dat_adr_o = run ? t[DW-1:1] : '0;
    assign dat_dat_o = run ? s : '0;
    assign shr_stb_o = ins_cyc_o | dat_cyc_o;
    assign commit    = shr_stb_o & shr_ack_i;
    assign ins_adr_o = pc;
    assign fault_o   = {rs_fault, ds_fault};

    always_comb begin
        case (op)
            OP_T:     alu = t;
            OP_S:     alu = s;
            OP_ADD:   alu = t + s;
            OP_AND:   alu = t & s;
            OP_OR:    alu = t | s;
            OP_XOR:   alu = t ^ s;
            OP_INV:   alu = ~t;
            OP_EQ:    alu = {DW{s == t}};
            OP_SLT:   alu = {DW{$signed(s) < $signed(t)}};
            OP_SHR:   alu = s >> t[SHW-1:0];
            OP_DEC:   alu = t - DW'(1);
            OP_R:     alu = r;
            OP_LD:    alu = dat_dat_i;
            OP_SHL:   alu = s << t[SHW-1:0];
            OP_DEPTH: alu = {HW'(rsp), HW'(dsp)};
            OP_ULT:   alu = {DW{s < t}};
            default:  alu = t;
        endcase
    end

    always_comb begin
        pc_n  = pc_inc;
        t_n   = t;
        ds_d  = 2'sd0;
        ds_we = 1'b0;
        rs_d  = 2'sd0;
        rs_we = 1'b0;
        rs_wd = t;
        if (irq_take) begin
            // Return address is the discarded instruction's own address.
            pc_n  = AW'(IRQ_VEC);
            rs_d  = 2'sd1;
            rs_we = 1'b1;
            rs_wd = DW'(pc);
        end else if (ins_dat_i[B_LIT]) begin
            t_n   = DW'(ins_dat_i[14:0]);
            ds_d  = 2'sd1;
            ds_we = 1'b1;
        end else begin
            case (ins_dat_i[14:13])
                CLS_JMP: pc_n = tgt;
                CLS_ZBR: begin
                    t_n  = s;
                    ds_d = -2'sd1;
                    if (t == '0) pc_n = tgt;
                end
                CLS_CALL: begin
                    pc_n  = tgt;
                    rs_d  = 2'sd1;
                    rs_we = 1'b1;
                    rs_wd = DW'(pc_inc);
                end
                default: begin
                    t_n   = alu;
                    ds_d  = ins_dat_i[1:0];
                    ds_we = ins_dat_i[B_TS];
                    rs_d  = ins_dat_i[3:2];
                    rs_we = ins_dat_i[B_TR];
                    if (ins_dat_i[B_RPC]) pc_n = AW'(r);
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_res_ni) begin
        if (!sys_res_ni) begin
            pc  <= AW'(RESET_VEC);
            t   <= '0;
            run <= 1'b0;
        end else begin
            run <= 1'b1;
            if (commit) begin
                pc <= pc_n;
                t  <= t_n;
            end
        end
    end

`ifdef J1B_IRQ_EN
    always_ff @(posedge sys_clk_i or negedge sys_res_ni) begin
        if (!sys_res_ni)
            ie <= 1'b0;
        else if (commit) begin
            if (irq_take)
                ie <= 1'b0;
            else if (is_alu && ins_dat_i[B_RETI])
                ie <= 1'b1;
        end
    end
`endif

    j1b_stack #(.DW(DW), .PW(DSP_W)) u_ds (
        .clk(sys_clk_i), .rst_n(sys_res_ni), .commit(commit), .delta(ds_d),
        .we(ds_we), .wd(t), .top(s), .ptr(dsp), .fault(ds_fault)
    );

    j1b_stack #(.DW(DW), .PW(RSP_W)) u_rs (
        .clk(sys_clk_i), .rst_n(sys_res_ni), .commit(commit), .delta(rs_d),
        .we(rs_we), .wd(rs_wd), .top(r), .ptr(rsp), .fault(rs_fault)
    );
endmodule

// File: tb/tb_j1b_core.sv
// tb_j1b_core: directed program run on a DW=32 j1b_core with a bench-side
// instruction ROM and data RAM; expected values are hand-computed.
module tb_j1b_core;
    localparam int DW = 32;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ack = 1'b0;
    logic [AW-1:0] ins_adr;
    logic [15:0]   ins_dat;
    logic          ins_cyc, dat_we, dat_cyc, shr_stb;
    logic [DW-2:0] dat_adr;
    logic [DW-1:0] dat_dout, dat_din;
    logic [1:0]    fault;
`ifdef J1B_IRQ_EN
    logic          irq = 1'b0;
`endif

    logic [15:0] imem [0:8191];
    logic [DW-1:0] dmem [0:255];
    wire unused_adr = ^dat_adr[DW-2:8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ins_dat = imem[ins_adr];
    assign dat_din = dmem[dat_adr[7:0]];

    always @(posedge clk)
        if (rst_n && dat_cyc && dat_we && ack) dmem[dat_adr[7:0]] <= dat_dout;

    j1b_core #(.DW(DW), .AW(AW), .DSP_W(5), .RSP_W(5), .RESET_VEC(0), .IRQ_VEC(1)) dut (
        .sys_clk_i(clk), .sys_res_ni(rst_n),
        .ins_adr_o(ins_adr), .ins_dat_i(ins_dat), .ins_cyc_o(ins_cyc),
        .dat_adr_o(dat_adr), .dat_dat_o(dat_dout), .dat_dat_i(dat_din),
        .dat_we_o(dat_we), .dat_cyc_o(dat_cyc), .shr_stb_o(shr_stb),
        .shr_ack_i(ack),
`ifdef J1B_IRQ_EN
        .irq_i(irq),
`endif
        .fault_o(fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) imem[i] = 16'h6000;  // NOP
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        imem[0]  = 16'h8005;   // lit 5
        imem[5]  = 16'h4123;   // call 0x123
        imem[16'h123] = 16'h700C; // ret
        imem[6]  = 16'hA152;   // lit 0x2152
        imem[7]  = 16'h8010;   // lit 16
        imem[8]  = 16'h6D03;   // S<<T
        imem[9]  = 16'hC110;   // lit 0x4110
        imem[10] = 16'h6403;   // or
        imem[11] = 16'h6600;   // invert -> DEADBEEF
        imem[12] = 16'h9000;   // lit 0x1000
        imem[13] = 16'h6020;   // store
        imem[14] = 16'h6C00;   // fetch
        imem[15] = 16'h8004;   // lit 4
        imem[16] = 16'h6903;   // S>>T
        imem[17] = 16'h6E81;   // depth, pushed
        imem[18] = 16'h6803;   // signed <
        imem[19] = 16'h6803;   // signed <
        imem[20] = 16'h6F03;   // unsigned <
        imem[21] = 16'h6703;   // ==
        imem[22] = 16'h8000;   // lit 0
        imem[23] = 16'h8001;   // lit 1
        imem[24] = 16'h2030;   // 0branch (T=1, falls through)
        imem[25] = 16'h2040;   // 0branch (T=0, taken)
        for (int i = 0; i < 33; i++) imem[16'h40 + i] = 16'h8000 | 16'(i + 1);
        imem[16'h61] = 16'h600C; // rsp -1 from empty

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", 64'(ins_adr), 64'h0);
        chk("rst_ins_cyc", 64'(ins_cyc), 64'h0);
        chk("rst_stb", 64'(shr_stb), 64'h0);
        chk("rst_dat_cyc", 64'(dat_cyc), 64'h0);
        chk("rst_dat_we", 64'(dat_we), 64'h0);
        chk("rst_fault", 64'(fault), 64'h0);
        chk("rst_t", 64'(dut.t), 64'h0);
        chk("rst_dsp", 64'(dut.u_ds.ptr), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ack = 1'b1;
        step();
        chk("rel_ins_cyc", 64'(ins_cyc), 64'h1);
        chk("rel_pc", 64'(ins_adr), 64'h0);
        step();
        chk("lit_t", 64'(dut.t), 64'h5);
        chk("lit_dsp", 64'(dut.u_ds.ptr), 64'h1);
        chk("lit_pc", 64'(ins_adr), 64'h1);

        // call / return
        repeat (4) step();
        chk("pre_call_pc", 64'(ins_adr), 64'h5);
        step();
        chk("call_pc", 64'(ins_adr), 64'h123);
        chk("call_rsp", 64'(dut.u_rs.ptr), 64'h1);
        chk("call_r", 64'(dut.r), 64'h6);
        step();
        chk("ret_pc", 64'(ins_adr), 64'h6);
        chk("ret_rsp", 64'(dut.u_rs.ptr), 64'h0);

        // Build DEADBEEF / 0x1000
        repeat (7) step();
        chk("st_pc", 64'(ins_adr), 64'd13);
        chk("st_t", 64'(dut.t), 64'h1000);
        chk("st_s", 64'(dut.s), 64'hDEADBEEF);

        // Store with 3 wait states
        ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("st_we", 64'(dat_we), 64'h1);
            chk("st_adr", 64'(dat_adr), 64'h800);
            chk("st_dat", 64'(dat_dout), 64'hDEADBEEF);
            chk("st_hold_pc", 64'(ins_adr), 64'd13);
            if (k == 3) ack = 1'b1;
            step();
        end
        chk("st_mem", 64'(dmem[0]), 64'hDEADBEEF);
        chk("st_done_pc", 64'(ins_adr), 64'd14);
        chk("st_t_kept", 64'(dut.t), 64'h1000);

        // Fetch with 3 wait states
        ack = 1'b0;
        repeat (3) step();
        chk("ld_hold_pc", 64'(ins_adr), 64'd14);
        chk("ld_cyc", 64'(dat_cyc), 64'h1);
        chk("ld_we", 64'(dat_we), 64'h0);
        chk("ld_hold_t", 64'(dut.t), 64'h1000);
        ack = 1'b1;
        step();
        chk("ld_t", 64'(dut.t), 64'hDEADBEEF);
        chk("ld_pc", 64'(ins_adr), 64'd15);

        // ALU ops
        repeat (2) step();
        chk("shr_t", 64'(dut.t), 64'h0DEADBEE);
        step();
        chk("depth_t", 64'(dut.t), 64'h3);
        chk("depth_dsp", 64'(dut.u_ds.ptr), 64'h4);
        step();
        chk("slt_pos_t", 64'(dut.t), 64'h0);
        step();
        chk("slt_neg_t", 64'(dut.t), 64'hFFFFFFFF);
        step();
        chk("ult_t", 64'(dut.t), 64'hFFFFFFFF);
        chk("ult_dsp", 64'(dut.u_ds.ptr), 64'h1);
        step();
        chk("eq_t", 64'(dut.t), 64'h0);
        chk("eq_dsp", 64'(dut.u_ds.ptr), 64'h0);

        // 0branch
        repeat (3) step();
        chk("zbr_nt_pc", 64'(ins_adr), 64'd25);
        chk("zbr_nt_dsp", 64'(dut.u_ds.ptr), 64'h1);
        step();
        chk("zbr_t_pc", 64'(ins_adr), 64'h40);
        chk("zbr_t_dsp", 64'(dut.u_ds.ptr), 64'h0);
        chk("zbr_fault", 64'(fault), 64'h0);

        // Data stack overflow
        repeat (31) step();
        chk("ovf31_dsp", 64'(dut.u_ds.ptr), 64'd31);
        chk("ovf31_fault", 64'(fault), 64'h0);
        step();
        chk("ovf32_dsp", 64'(dut.u_ds.ptr), 64'h0);
        chk("ovf32_fault", 64'(fault), 64'h1);
        step();
        chk("ovf33_dsp", 64'(dut.u_ds.ptr), 64'h1);
        chk("ovf33_fault", 64'(fault), 64'h1);
        chk("ovf33_t", 64'(dut.t), 64'd33);

        // Return stack underflow
        step();
        chk("unf_rsp", 64'(dut.u_rs.ptr), 64'd31);
        chk("unf_fault", 64'(fault), 64'h3);
        chk("unf_pc", 64'(ins_adr), 64'h62);

        // Reset during a pending cycle
        ack = 1'b0;
        step();
        chk("pend_stb", 64'(shr_stb), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ins_cyc", 64'(ins_cyc), 64'h0);
        chk("arst_stb", 64'(shr_stb), 64'h0);
        chk("arst_pc", 64'(ins_adr), 64'h0);
        chk("arst_fault", 64'(fault), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
